wbu: RTL and testbench

Write-back unit: final stage of the multi-cycle NPC core. It sits directly downstream of the load/store stage, consumes its 104-bit result packet, and selects ALU result or load data. It commits the selected value to the integrated 32×32 general register file and raises a one-cycle commit pulse, with PC, for difftest. It also keeps a retired-instruction counter and stops accepting packets after `ebreak`.

---
 rtl/npc_pkg.sv | 31 +++
 rtl/wbu_reg_file.sv | 56 +++++
 rtl/wbu.sv | 172 +++++++++++++++++
 tb/tb_wbu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core back end.
// Holds the write-back FSM state type, the load/store -> write-back packet
// width and field offsets, and the write-data selection helper.
package npc_pkg;

    // Load/store result packet layout (LSB offsets of each field)
    localparam int WB_PKT_W    = 104;
    localparam int ALU_RES_LSB = 72;
    localparam int LOAD_LSB    = 40;
    localparam int PC_LSB      = 8;
    localparam int RD_LSB      = 3;
    localparam int RF_WEN_BIT  = 2;
    localparam int M2R_BIT     = 1;
    localparam int EBREAK_BIT  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HALT  = 2'd2
    } wbu_state_t;

    // Write-back data: load data for loads, ALU result otherwise
    function automatic logic [31:0] wb_select(
        input logic        mem_to_reg,
        input logic [31:0] alu_res,
        input logic [31:0] load_data
    );
        return mem_to_reg ? load_data : alu_res;
    endfunction

endpackage

// File: rtl/wbu_reg_file.sv
// General register file for the write-back unit.
// One synchronous write port, two combinational read ports, async
// active-high reset clearing every entry. Entry 0 is never written and
// always reads as zero.
// Ports:
//   clk, rst             clock, async active-high reset
//   wen, waddr, wdata    write port (takes effect on rising clk)
//   raddr1/rdata1        read port 1 (combinational)
//   raddr2/rdata2        read port 2 (combinational)
module reg_file #(
    parameter int NR_REGS = 32,
    parameter int AW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr1,
    output logic [31:0]   rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [31:0]   rdata2
);

    logic [31:0] regs_r [NR_REGS];

    // Register storage: cleared on reset, x0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wen && (waddr != {AW{1'b0}})) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port 1 with x0 forced to zero
    always_comb begin
        if (raddr1 == {AW{1'b0}}) begin
            rdata1 = 32'd0;
        end else begin
            rdata1 = regs_r[raddr1];
        end
    end

    // Read port 2 with x0 forced to zero
    always_comb begin
        if (raddr2 == {AW{1'b0}}) begin
            rdata2 = 32'd0;
        end else begin
            rdata2 = regs_r[raddr2];
        end
    end

endmodule

// File: rtl/wbu.sv
// Write-back unit: last stage of the multi-cycle NPC core.
// Accepts one load/store result packet per handshake, selects ALU result
// or load data, writes the register file, pulses commit_valid with the
// PC for one cycle, counts retired instructions and halts after ebreak.
// The packet is not copied: upstream holds lsu_data stable during S_WRITE.
// Optional feature macro: WBU_BYPASS_EN -- forwards the value being
// written to a same-cycle read of that register during S_WRITE.
// Ports:
//   clk, rst              clock, async active-high reset
//   lsu_valid, lsu_data   upstream packet (see npc_pkg for layout)
//   wbu_ready             stage can accept a packet (S_IDLE)
//   rs1/rs2_addr, _data   combinational register reads for the IDU
//   commit_valid          one-cycle retire pulse
//   commit_pc             PC of the retiring instruction (held afterwards)
//   retire_cnt            retired-instruction counter (wraps)
//   halted                sticky, set when ebreak retires
module wbu
    import npc_pkg::*;
#(
    parameter int NR_REGS = 32,
    parameter int CNT_W   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_valid,
    input  logic [WB_PKT_W-1:0] lsu_data,
    output logic                wbu_ready,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic [31:0]         rs1_data,
    output logic [31:0]         rs2_data,
    output logic                commit_valid,
    output logic [31:0]         commit_pc,
    output logic [CNT_W-1:0]    retire_cnt,
    output logic                halted
);

    wbu_state_t       state_r;
    wbu_state_t       state_s;
    logic             ready_r;
    logic             commit_r;
    logic             halted_r;
    logic [CNT_W-1:0] retire_cnt_r;
    logic [31:0]      pc_hold_r;

    logic [31:0] pkt_alu_s;
    logic [31:0] pkt_load_s;
    logic [31:0] pkt_pc_s;
    logic [4:0]  pkt_rd_s;
    logic        pkt_wen_s;
    logic        pkt_m2r_s;
    logic        pkt_ebreak_s;
    logic [31:0] wdata_s;
    logic        rf_wen_s;
    logic [31:0] rf_rd1_s;
    logic [31:0] rf_rd2_s;

    assign pkt_alu_s    = lsu_data[ALU_RES_LSB +: 32];
    assign pkt_load_s   = lsu_data[LOAD_LSB +: 32];
    assign pkt_pc_s     = lsu_data[PC_LSB +: 32];
    assign pkt_rd_s     = lsu_data[RD_LSB +: 5];
    assign pkt_wen_s    = lsu_data[RF_WEN_BIT];
    assign pkt_m2r_s    = lsu_data[M2R_BIT];
    assign pkt_ebreak_s = lsu_data[EBREAK_BIT];

    assign wdata_s = wb_select(pkt_m2r_s, pkt_alu_s, pkt_load_s);
    // commit_r is high exactly while in S_WRITE
    assign rf_wen_s = commit_r & pkt_wen_s & (pkt_rd_s != 5'd0);

    // Next-state logic; ready is high only in S_IDLE so lsu_valid alone
    // completes the handshake there
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (lsu_valid) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WRITE: begin
                if (pkt_ebreak_s) begin
                    state_s = S_HALT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HALT:  state_s = S_HALT;
            default: state_s = S_IDLE;
        endcase
    end

    // State register plus flag outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            ready_r  <= 1'b1;
            commit_r <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            ready_r  <= (state_s == S_IDLE);
            commit_r <= (state_s == S_WRITE);
            halted_r <= (state_s == S_HALT);
        end
    end

    // Retire counter and last committed PC, updated at the S_WRITE exit edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_r <= {CNT_W{1'b0}};
            pc_hold_r    <= 32'd0;
        end else if (commit_r) begin
            retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            pc_hold_r    <= pkt_pc_s;
        end
    end

    // PC comes straight from the stable packet during commit, else held value
    always_comb begin
        if (commit_r) begin
            commit_pc = pkt_pc_s;
        end else begin
            commit_pc = pc_hold_r;
        end
    end

    reg_file #(
        .NR_REGS (NR_REGS),
        .AW      (5)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .wen    (rf_wen_s),
        .waddr  (pkt_rd_s),
        .wdata  (wdata_s),
        .raddr1 (rs1_addr),
        .rdata1 (rf_rd1_s),
        .raddr2 (rs2_addr),
        .rdata2 (rf_rd2_s)
    );

`ifdef WBU_BYPASS_EN
    // Forward the in-flight write to port 1 (rf_wen_s already excludes x0)
    always_comb begin
        if (rf_wen_s && (rs1_addr == pkt_rd_s)) begin
            rs1_data = wdata_s;
        end else begin
            rs1_data = rf_rd1_s;
        end
    end

    // Forward the in-flight write to port 2
    always_comb begin
        if (rf_wen_s && (rs2_addr == pkt_rd_s)) begin
            rs2_data = wdata_s;
        end else begin
            rs2_data = rf_rd2_s;
        end
    end
`else
    assign rs1_data = rf_rd1_s;
    assign rs2_data = rf_rd2_s;
`endif

    assign wbu_ready    = ready_r;
    assign commit_valid = commit_r;
    assign retire_cnt   = retire_cnt_r;
    assign halted       = halted_r;

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: directed cases plus randomized packets
// compared against a behavioural register/counter model.
module tb_wbu;

    logic         clk;
    logic         rst;
    logic         lsu_valid;
    logic [103:0] lsu_data;
    logic         wbu_ready;
    logic [4:0]   rs1_addr;
    logic [4:0]   rs2_addr;
    logic [31:0]  rs1_data;
    logic [31:0]  rs2_data;
    logic         commit_valid;
    logic [31:0]  commit_pc;
    logic [63:0]  retire_cnt;
    logic         halted;

    wbu #(.NR_REGS(32), .CNT_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_valid    (lsu_valid),
        .lsu_data     (lsu_data),
        .wbu_ready    (wbu_ready),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .retire_cnt   (retire_cnt),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;
    logic [31:0] m_pc;
    logic        m_halt;

    int n_vec;
    int n_err;
    int pulses;

    always @(negedge clk) begin
        if (commit_valid === 1'b1) pulses++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [103:0] mk(input logic [31:0] alu, input logic [31:0] ld,
                                        input logic [31:0] pc, input int rd,
                                        input bit wen, input bit m2r, input bit eb);
        logic [4:0] r;
        r = rd[4:0];
        return {alu, ld, pc, r, wen, m2r, eb};
    endfunction

    // Expected read: x0 is zero, optional forward of the in-flight write
    function automatic logic [31:0] rexp(input int addr, input bit in_wr, input int rd,
                                         input bit wen, input logic [31:0] wd);
        if (addr == 0) return 32'd0;
`ifdef WBU_BYPASS_EN
        if (in_wr && wen && rd == addr) return wd;
`endif
        return m_regs[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt  = 64'd0;
        m_pc   = 32'd0;
        m_halt = 1'b0;
    endtask

    // Called at a negedge in S_IDLE; returns at the negedge after retirement
    task automatic send(input logic [103:0] p, input bit keep_valid);
        logic [31:0] alu, ld, pc, wd;
        int rd, a2;
        bit wen, m2r, eb;
        alu = p[103:72]; ld = p[71:40]; pc = p[39:8];
        rd = int'(p[7:3]); wen = p[2]; m2r = p[1]; eb = p[0];
        wd = m2r ? ld : alu;
        a2 = $urandom_range(0, 31);
        check_val("ready_idle", {63'd0, wbu_ready}, 64'd1);
        lsu_valid = 1'b1;
        lsu_data  = p;
        rs1_addr  = rd[4:0];
        rs2_addr  = a2[4:0];
        @(posedge clk);
        @(negedge clk);
        check_val("commit_valid", {63'd0, commit_valid}, 64'd1);
        check_val("commit_pc", {32'd0, commit_pc}, {32'd0, pc});
        check_val("ready_write", {63'd0, wbu_ready}, 64'd0);
        check_val("rs1_in_write", {32'd0, rs1_data}, {32'd0, rexp(rd, 1'b1, rd, wen, wd)});
        check_val("rs2_in_write", {32'd0, rs2_data}, {32'd0, rexp(a2, 1'b1, rd, wen, wd)});
        lsu_valid = keep_valid;
        @(posedge clk);
        if (wen && rd != 0) m_regs[rd] = wd;
        m_cnt = m_cnt + 64'd1;
        m_pc  = pc;
        if (eb) m_halt = 1'b1;
        @(negedge clk);
        check_val("commit_after", {63'd0, commit_valid}, 64'd0);
        check_val("retire_cnt", retire_cnt, m_cnt);
        check_val("pc_held", {32'd0, commit_pc}, {32'd0, m_pc});
        check_val("halted", {63'd0, halted}, {63'd0, m_halt});
        check_val("ready_after", {63'd0, wbu_ready}, {63'd0, !m_halt});
        check_val("rs1_after", {32'd0, rs1_data}, {32'd0, rexp(rd, 1'b0, rd, wen, wd)});
    endtask

    task automatic idle(input int n);
        lsu_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val("idle_no_commit", {63'd0, commit_valid}, 64'd0);
        end
    endtask

    task automatic check_all_zero();
        for (int a = 0; a < 32; a++) begin
            rs1_addr = a[4:0];
            #1;
            check_val("reg_zero", {32'd0, rs1_data}, 64'd0);
        end
    endtask

    initial begin
        int p0;
        n_vec = 0; n_err = 0; pulses = 0;
        rst = 1'b1; lsu_valid = 1'b0; lsu_data = 104'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_ready", {63'd0, wbu_ready}, 64'd1);
        check_val("rst_commit", {63'd0, commit_valid}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_cnt", retire_cnt, 64'd0);
        check_val("rst_pc", {32'd0, commit_pc}, 64'd0);
        check_val("rst_halted", {63'd0, halted}, 64'd0);
        check_all_zero();

        // Populate some registers so the mid-write reset has work to undo
        for (int i = 0; i < 6; i++)
            send(mk($urandom, $urandom, $urandom, i + 1, 1'b1, 1'b0, 1'b0), 1'b0);

        // Reset asserted during S_WRITE aborts the write
        lsu_valid = 1'b1;
        lsu_data  = mk(32'hAAAA_5555, 32'd0, 32'h1000, 9, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_val("pre_abort_commit", {63'd0, commit_valid}, 64'd1);
        rst = 1'b1;
        lsu_valid = 1'b0;
        #1;
        check_val("abort_commit", {63'd0, commit_valid}, 64'd0);
        check_val("abort_cnt", retire_cnt, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_ready", {63'd0, wbu_ready}, 64'd1);
        check_val("abort_cnt_after", retire_cnt, 64'd0);
        check_all_zero();

        // Directed write-back cases
        send(mk(32'h1234_5678, 32'd0, 32'h8000_0000, 5, 1'b1, 1'b0, 1'b0), 1'b0);
        check_val("alu_cnt1", retire_cnt, 64'd1);
        idle(1);
        send(mk(32'hDEAD_BEEF, 32'hFFFF_FF80, 32'h8000_0004, 10, 1'b1, 1'b1, 1'b0), 1'b0);
        rs2_addr = 5'd10; #1;
        check_val("load_x10", {32'd0, rs2_data}, 64'h0000_0000_FFFF_FF80);
        send(mk(32'hFFFF_FFFF, 32'd0, 32'h8000_0008, 0, 1'b1, 1'b0, 1'b0), 1'b0);
        rs2_addr = 5'd0; #1;
        check_val("x0_zero", {32'd0, rs2_data}, 64'd0);

        // Back-to-back with lsu_valid held high
        model_reset();
        rst = 1'b1; #1; rst = 1'b0;
        @(negedge clk);
        p0 = pulses;
        for (int i = 0; i < 6; i++)
            send(mk($urandom, $urandom, 32'h100 + 32'(i * 4), int'($urandom_range(0, 31)),
                    1'b1, bit'($urandom_range(0, 1)), 1'b0), i != 5);
        check_val("b2b_pulses", 64'(pulses - p0), 64'd6);
        check_val("b2b_cnt", retire_cnt, 64'd6);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            send(mk($urandom, $urandom, $urandom, int'($urandom_range(0, 31)),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0),
                 bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        // ebreak: give x1 a known old value first, then halt
        idle(1);
        send(mk(32'h0000_0055, 32'd0, 32'h2000, 1, 1'b1, 1'b0, 1'b0), 1'b0);
        send(mk(32'h0000_0007, 32'd0, 32'h2004, 1, 1'b1, 1'b0, 1'b1), 1'b1);
        p0 = pulses;
        lsu_data = mk(32'h0BAD, 32'd0, 32'h2008, 2, 1'b1, 1'b0, 1'b0);
        rs1_addr = 5'd1;
        repeat (5) @(negedge clk);
        check_val("halt_pulses", 64'(pulses - p0), 64'd0);
        check_val("halt_ready", {63'd0, wbu_ready}, 64'd0);
        check_val("halt_sticky", {63'd0, halted}, 64'd1);
        check_val("halt_cnt", retire_cnt, m_cnt);
        check_val("halt_x1", {32'd0, rs1_data}, 64'd7);
        lsu_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
